ahb_slave_mem: RTL and testbench

//  AHB-Lite responder (slave) backed by a word-addressed register-file memory; the bus-side counterpart to the AHB master.

---
 rtl/ahb_pkg.sv | 23 ++
 rtl/ahb_slave_mem_if.sv | 24 ++
 rtl/ahb_slv_lane_dec.sv | 25 ++
 rtl/ahb_slave_mem.sv | 153 +++++++++++++++
 tb/tb_ahb_slave_mem.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the responder FSM state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_ERR1 = 2'b10,
    ST_ERR2 = 2'b11
  } slv_state_t;

endpackage

// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite bus bundle between a master/decoder and the scratch-memory responder.
interface ahb_slave_mem_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        hready_in;
  logic [31:0] hwdata;
  logic        hready_out;
  logic [1:0]  hresp;
  logic [31:0] hr_data;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hready_in, hwdata,
    input  hready_out, hresp, hr_data
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hready_in, hwdata,
    output hready_out, hresp, hr_data
  );
endinterface

// File: rtl/ahb_slv_lane_dec.sv
// Byte-lane decode for a little-endian 32-bit bus: address low bits + hsize -> lane mask.
module ahb_slv_lane_dec
  import ahb_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  logic [2:0] hsize,
  output logic [3:0] lane_mask,
  output logic       misalign
);

  always_comb begin
    lane_mask = 4'b1111;
    misalign  = 1'b0;
    case (hsize)
      HSIZE_BYTE: lane_mask = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
        misalign  = addr_lo[0];
      end
      // word and oversize transfers use all four lanes
      default:    misalign = (addr_lo != 2'b00);
    endcase
  end

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite scratch-memory responder with configurable wait states.
// Define AHB_SLV_ERR_EN to answer bad address/size/alignment with a two-cycle ERROR.
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH       = 256,
  parameter int          WAIT_STATES = 0
) (
  input  logic           hclk,
  input  logic           hreset,
  ahb_slave_mem_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  slv_state_t    state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          pend_wr_q, pend_wr_d;
  logic          pend_rd_q, pend_rd_d;
  logic [AW-1:0] pend_idx_q, pend_idx_d;
  logic [3:0]    pend_mask_q, pend_mask_d;
  logic [31:0]   rd_word_q, rd_word_d;
  logic [31:0]   hr_data_q, hr_data_d;

  logic [31:0]   offset;
  logic [AW-1:0] acc_idx;
  logic [3:0]    lane_mask;
  logic          misalign;
  logic          accept;
  logic          acc_err;
  logic          wr_en;
  logic [31:0]   acc_word;
  logic          unused_ok;

  assign offset  = bus.haddr - BASE_ADDR;
  assign acc_idx = offset[AW+1:2];
  assign accept  = bus.hsel & bus.htrans[1] & bus.hready_in;
  assign wr_en   = (state_q == ST_DATA) && (cnt_q == 3'd0) && pend_wr_q;

  ahb_slv_lane_dec u_lane_dec (
    .addr_lo   (bus.haddr[1:0]),
    .hsize     (bus.hsize),
    .lane_mask (lane_mask),
    .misalign  (misalign)
  );

`ifdef AHB_SLV_ERR_EN
  assign acc_err = (offset >= 32'(4 * DEPTH)) | (bus.hsize >= 3'b011) | misalign;
`else
  assign acc_err = 1'b0;
`endif

  assign unused_ok = ^{bus.hburst, bus.htrans[0], offset, misalign};

  // One byte-wide array per lane; a read accepted on the committing edge of a
  // write to the same word sees the incoming bytes instead of the stale ones.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem_lane [DEPTH];

      always_ff @(posedge hclk) begin
        if (!hreset && wr_en && pend_mask_q[gi])
          mem_lane[pend_idx_q] <= bus.hwdata[8*gi +: 8];
      end

      assign acc_word[8*gi +: 8] =
        (wr_en && pend_mask_q[gi] && (pend_idx_q == acc_idx)) ? bus.hwdata[8*gi +: 8]
                                                               : mem_lane[acc_idx];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_wr_d   = pend_wr_q;
    pend_rd_d   = pend_rd_q;
    pend_idx_d  = pend_idx_q;
    pend_mask_d = pend_mask_q;
    rd_word_d   = rd_word_q;
    hr_data_d   = hr_data_q;

    if (state_q == ST_DATA && cnt_q != 3'd0) begin
      cnt_d = cnt_q - 3'd1;
      // load the output on the edge that enters the completing cycle
      if (cnt_q == 3'd1 && pend_rd_q)
        hr_data_d = rd_word_q;
    end else if (state_q == ST_ERR1) begin
      state_d = ST_ERR2;
    end else begin
      state_d   = ST_IDLE;
      pend_wr_d = 1'b0;
      pend_rd_d = 1'b0;
      if (accept) begin
        if (acc_err) begin
          state_d = ST_ERR1;
        end else begin
          state_d     = ST_DATA;
          cnt_d       = 3'(WAIT_STATES);
          pend_wr_d   = bus.hwrite;
          pend_rd_d   = ~bus.hwrite;
          pend_idx_d  = acc_idx;
          pend_mask_d = lane_mask;
          if (!bus.hwrite) begin
            rd_word_d = acc_word;
            if (WAIT_STATES == 0)
              hr_data_d = acc_word;
          end
        end
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      pend_wr_q   <= 1'b0;
      pend_rd_q   <= 1'b0;
      pend_idx_q  <= '0;
      pend_mask_q <= 4'b0000;
      rd_word_q   <= 32'h0;
      hr_data_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_wr_q   <= pend_wr_d;
      pend_rd_q   <= pend_rd_d;
      pend_idx_q  <= pend_idx_d;
      pend_mask_q <= pend_mask_d;
      rd_word_q   <= rd_word_d;
      hr_data_q   <= hr_data_d;
    end
  end

  always_comb begin
    bus.hready_out = 1'b1;
    bus.hresp      = HRESP_OKAY;
    case (state_q)
      ST_DATA: bus.hready_out = (cnt_q == 3'd0);
      ST_ERR1: begin
        bus.hready_out = 1'b0;
        bus.hresp      = HRESP_ERROR;
      end
      ST_ERR2: bus.hresp = HRESP_ERROR;
      default: ;
    endcase
  end

  assign bus.hr_data = hr_data_q;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench: zero-wait instance for data/lane/bypass/reset cases, two-wait instance for stretching.
module tb_ahb_slave_mem;
  import ahb_pkg::*;

  logic clk = 1'b0;
  logic hreset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ahb_slave_mem_if bus0 ();
  ahb_slave_mem_if bus2 ();

  // single-slave bus: HREADY seen by the slave is its own hready_out
  assign bus0.hready_in = bus0.hready_out;
  assign bus2.hready_in = bus2.hready_out;

  ahb_slave_mem #(.BASE_ADDR(32'h8000_0000), .DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .hclk(clk), .hreset(hreset), .bus(bus0)
  );
  ahb_slave_mem #(.BASE_ADDR(32'h8000_0000), .DEPTH(256), .WAIT_STATES(2)) u_dut2 (
    .hclk(clk), .hreset(hreset), .bus(bus2)
  );

  task automatic drv(input int d, input logic sel, input logic [31:0] a,
                     input logic [1:0] tr, input logic wr, input logic [2:0] sz);
    if (d == 0) begin
      bus0.hsel = sel; bus0.haddr = a; bus0.htrans = tr; bus0.hwrite = wr;
      bus0.hsize = sz; bus0.hburst = 3'b000;
    end else begin
      bus2.hsel = sel; bus2.haddr = a; bus2.htrans = tr; bus2.hwrite = wr;
      bus2.hsize = sz; bus2.hburst = 3'b000;
    end
  endtask

  task automatic idle(input int d);
    drv(d, 1'b0, 32'h0, HTRANS_IDLE, 1'b0, HSIZE_WORD);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // simple zero-wait write on instance 0, data phase completes on the following edge
  task automatic write0(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] data);
    drv(0, 1'b1, a, HTRANS_NONSEQ, 1'b1, sz);
    tick();
    bus0.hwdata = data;
    idle(0);
    tick();
  endtask

  // zero-wait read on instance 0, result sampled in the data phase
  task automatic read0(input string tag, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] exp);
    drv(0, 1'b1, a, HTRANS_NONSEQ, 1'b0, sz);
    tick();
    idle(0);
    @(negedge clk);
    chk({tag, "_rdy"}, bus0.hready_out, 1'b1);
    chk({tag, "_data"}, bus0.hr_data, exp);
    #1;
  endtask

  initial begin
    idle(0); idle(2);
    bus0.hwdata = 32'h0; bus2.hwdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 hreset = 1'b0;
    @(negedge clk);
    chk("rst_rdy0", bus0.hready_out, 1'b1);
    chk("rst_resp0", bus0.hresp, HRESP_OKAY);
    chk("rst_data0", bus0.hr_data, 32'h0);
    chk("rst_rdy2", bus2.hready_out, 1'b1);
    chk("rst_data2", bus2.hr_data, 32'h0);
    #1;

    // preload words 0 and 1
    write0(32'h8000_0000, HSIZE_WORD, 32'h0000_0000);
    write0(32'h8000_0004, HSIZE_WORD, 32'h1111_1111);

    // byte write lane 1, then back-to-back byte read of the same word
    drv(0, 1'b1, 32'h8000_0001, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE);
    tick();
    bus0.hwdata = 32'h8202_0613;
    drv(0, 1'b1, 32'h8000_0003, HTRANS_NONSEQ, 1'b0, HSIZE_BYTE);
    @(negedge clk);
    chk("bw_rdy", bus0.hready_out, 1'b1);
    chk("bw_resp", bus0.hresp, HRESP_OKAY);
    tick();
    idle(0);
    @(negedge clk);
    chk("br_data", bus0.hr_data, 32'h0000_0600);
    chk("br_resp", bus0.hresp, HRESP_OKAY);
    #1;
    read0("w0_rd", 32'h8000_0000, HSIZE_WORD, 32'h0000_0600);

    // word write then back-to-back read of the same address
    drv(0, 1'b1, 32'h8000_0010, HTRANS_NONSEQ, 1'b1, HSIZE_WORD);
    tick();
    bus0.hwdata = 32'hDEAD_BEEF;
    drv(0, 1'b1, 32'h8000_0010, HTRANS_NONSEQ, 1'b0, HSIZE_WORD);
    tick();
    idle(0);
    @(negedge clk);
    chk("byp_data", bus0.hr_data, 32'hDEAD_BEEF);
    #1;

    // upper halfword write
    write0(32'h8000_0012, HSIZE_HALF, 32'h1234_5678);
    read0("half_rd", 32'h8000_0010, HSIZE_WORD, 32'h1234_BEEF);

    // IDLE with hsel high: no data phase, memory untouched, hr_data held
    drv(0, 1'b1, 32'h8000_0010, HTRANS_IDLE, 1'b1, HSIZE_WORD);
    tick();
    bus0.hwdata = 32'hFFFF_FFFF;
    idle(0);
    @(negedge clk);
    chk("idle_rdy", bus0.hready_out, 1'b1);
    chk("idle_resp", bus0.hresp, HRESP_OKAY);
    chk("idle_hold", bus0.hr_data, 32'h1234_BEEF);
    #1;
    tick();
    read0("idle_mem", 32'h8000_0010, HSIZE_WORD, 32'h1234_BEEF);

    // out-of-range read one word past the top
`ifdef AHB_SLV_ERR_EN
    drv(0, 1'b1, 32'h8000_0400, HTRANS_NONSEQ, 1'b0, HSIZE_WORD);
    tick();
    idle(0);
    @(negedge clk);
    chk("err1_rdy", bus0.hready_out, 1'b0);
    chk("err1_resp", bus0.hresp, HRESP_ERROR);
    tick();
    @(negedge clk);
    chk("err2_rdy", bus0.hready_out, 1'b1);
    chk("err2_resp", bus0.hresp, HRESP_ERROR);
    tick();
    @(negedge clk);
    chk("err_done_resp", bus0.hresp, HRESP_OKAY);
    chk("err_hold", bus0.hr_data, 32'h1234_BEEF);
    #1;
`else
    drv(0, 1'b1, 32'h8000_0400, HTRANS_NONSEQ, 1'b0, HSIZE_WORD);
    tick();
    idle(0);
    @(negedge clk);
    chk("wrap_resp", bus0.hresp, HRESP_OKAY);
    chk("wrap_data", bus0.hr_data, 32'h0000_0600);
    #1;
`endif

    // reset asserted during a write data phase
    drv(0, 1'b1, 32'h8000_0004, HTRANS_NONSEQ, 1'b1, HSIZE_WORD);
    tick();
    bus0.hwdata = 32'hCAFE_F00D;
    idle(0);
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
    @(negedge clk);
    chk("mrst_rdy", bus0.hready_out, 1'b1);
    chk("mrst_resp", bus0.hresp, HRESP_OKAY);
    chk("mrst_data", bus0.hr_data, 32'h0);
    #1;
    read0("mrst_mem", 32'h8000_0004, HSIZE_WORD, 32'h1111_1111);

    // two-wait instance: word write then word read
    drv(2, 1'b1, 32'h8000_0008, HTRANS_NONSEQ, 1'b1, HSIZE_WORD);
    tick();
    bus2.hwdata = 32'hA5A5_5A5A;
    idle(2);
    @(negedge clk);
    chk("w2_wait1", bus2.hready_out, 1'b0);
    tick();
    @(negedge clk);
    chk("w2_wait2", bus2.hready_out, 1'b0);
    tick();
    @(negedge clk);
    chk("w2_done", bus2.hready_out, 1'b1);
    tick();
    drv(2, 1'b1, 32'h8000_0008, HTRANS_NONSEQ, 1'b0, HSIZE_WORD);
    tick();
    idle(2);
    @(negedge clk);
    chk("r2_wait1", bus2.hready_out, 1'b0);
    chk("r2_hold", bus2.hr_data, 32'h0);
    tick();
    @(negedge clk);
    chk("r2_wait2", bus2.hready_out, 1'b0);
    tick();
    @(negedge clk);
    chk("r2_done", bus2.hready_out, 1'b1);
    chk("r2_data", bus2.hr_data, 32'hA5A5_5A5A);
    chk("r2_resp", bus2.hresp, HRESP_OKAY);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
